// File: rtl/banked_register_file_pkg.sv
// Shared types and constants for the banked ARMv7-M register file.
package regfile_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t   REG_SP         = 4'd13;
  localparam reg_addr_t   REG_LR         = 4'd14;
  localparam reg_addr_t   REG_PC         = 4'd15;
  localparam logic [31:0] LR_RESET       = 32'hFFFF_FFFF;
  localparam int          PC_READ_OFFSET = 4;

endpackage

// File: rtl/banked_register_file_if.sv
// Decode/writeback bus of the banked register file: read ports, write ports,
// PC update path and scoreboard set port.
interface banked_register_file_if
  import regfile_pkg::*;
#(
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2,
  parameter int DATA_W = 32
);

  reg_addr_t   [NUM_RD-1:0]             rd_addr;
  logic        [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic        [NUM_RD-1:0]             rd_busy;
  logic        [NUM_WR-1:0]             wr_en;
  reg_addr_t   [NUM_WR-1:0]             wr_addr;
  logic        [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic                                 spsel;
  logic                                 pc_we;
  logic        [DATA_W-1:0]             pc_next;
  logic        [DATA_W-1:0]             pc;
  logic                                 sb_set_en;
  reg_addr_t                            sb_set_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, spsel, pc_we, pc_next,
           sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, pc
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, spsel, pc_we, pc_next,
           sb_set_en, sb_set_addr,
    output rd_data, rd_busy, pc
  );

endinterface

// File: rtl/banked_register_file_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set by decode,
// cleared by writeback. Honours BANKED_REGFILE_BYPASS_EN for same-cycle clears.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_en,
  input  reg_addr_t               set_addr,
  input  logic      [NUM_WR-1:0]  clr_en,
  input  reg_addr_t [NUM_WR-1:0]  clr_addr,
  input  reg_addr_t [NUM_RD-1:0]  rd_addr,
  output logic      [NUM_RD-1:0]  rd_busy
);

  logic [15:0] pend_q;
  logic [15:0] pend_d;
  logic [15:0] clr_vec;

  always_comb begin
    clr_vec = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (clr_en[w]) clr_vec[clr_addr[w]] = 1'b1;
    end
  end

  // A set overrides a clear of the same bit: a new producer has just issued.
  always_comb begin
    pend_d = pend_q & ~clr_vec;
    if (set_en) pend_d[set_addr] = 1'b1;
    pend_d[REG_PC] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
`ifdef BANKED_REGFILE_BYPASS_EN
      rd_busy[k] = pend_q[rd_addr[k]] & ~clr_vec[rd_addr[k]];
`else
      rd_busy[k] = pend_q[rd_addr[k]];
`endif
    end
  end

endmodule

// File: rtl/banked_register_file.sv
// Multi-port ARMv7-M register file with banked MSP/PSP, PC update path and
// pending-write scoreboard. Optional write-to-read bypass: BANKED_REGFILE_BYPASS_EN.
module banked_register_file
  import regfile_pkg::*;
#(
  parameter int                NUM_RD    = 3,
  parameter int                NUM_WR    = 2,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_MSP = 32'h2000_0000,
  parameter logic [DATA_W-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  banked_register_file_if.slave   bus
);

  localparam logic [DATA_W-1:0] SP_MASK = ~DATA_W'(3);
  localparam logic [DATA_W-1:0] PC_MASK = ~DATA_W'(1);

  logic [DATA_W-1:0] gpr_q [13];
  logic [DATA_W-1:0] gpr_d [13];
  logic [DATA_W-1:0] msp_q, msp_d;
  logic [DATA_W-1:0] psp_q, psp_d;
  logic [DATA_W-1:0] lr_q,  lr_d;
  logic [DATA_W-1:0] pc_q,  pc_d;

  // Ports are applied in ascending order so the highest index wins collisions,
  // and a port write to R15 overrides the sequential pc_we update.
  always_comb begin
    gpr_d = gpr_q;
    msp_d = msp_q;
    psp_d = psp_q;
    lr_d  = lr_q;
    pc_d  = bus.pc_we ? (bus.pc_next & PC_MASK) : pc_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en[w]) begin
        if (bus.wr_addr[w] == REG_PC) begin
          pc_d = bus.wr_data[w] & PC_MASK;
        end else if (bus.wr_addr[w] == REG_LR) begin
          lr_d = bus.wr_data[w];
        end else if (bus.wr_addr[w] == REG_SP) begin
          if (bus.spsel) psp_d = bus.wr_data[w] & SP_MASK;
          else           msp_d = bus.wr_data[w] & SP_MASK;
        end else begin
          gpr_d[bus.wr_addr[w]] = bus.wr_data[w];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 13; i++) gpr_q[i] <= '0;
      msp_q <= RESET_MSP & SP_MASK;
      psp_q <= '0;
      lr_q  <= DATA_W'(LR_RESET);
      pc_q  <= RESET_PC;
    end else begin
      gpr_q <= gpr_d;
      msp_q <= msp_d;
      psp_q <= psp_d;
      lr_q  <= lr_d;
      pc_q  <= pc_d;
    end
  end

  // With bypass the read view is the next-state values, which already hold the
  // winning write data; R15 always comes from the registered PC.
  logic [DATA_W-1:0] gpr_v [13];
  logic [DATA_W-1:0] msp_v, psp_v, lr_v;

`ifdef BANKED_REGFILE_BYPASS_EN
  assign gpr_v = gpr_d;
  assign msp_v = msp_d;
  assign psp_v = psp_d;
  assign lr_v  = lr_d;
`else
  assign gpr_v = gpr_q;
  assign msp_v = msp_q;
  assign psp_v = psp_q;
  assign lr_v  = lr_q;
`endif

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (bus.rd_addr[k] == REG_PC)      bus.rd_data[k] = pc_q + DATA_W'(PC_READ_OFFSET);
      else if (bus.rd_addr[k] == REG_LR) bus.rd_data[k] = lr_v;
      else if (bus.rd_addr[k] == REG_SP) bus.rd_data[k] = bus.spsel ? psp_v : msp_v;
      else                               bus.rd_data[k] = gpr_v[bus.rd_addr[k]];
    end
  end

  assign bus.pc = pc_q;

  regfile_scoreboard #(
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (bus.sb_set_en),
    .set_addr (bus.sb_set_addr),
    .clr_en   (bus.wr_en),
    .clr_addr (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (bus.rd_busy)
  );

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench for banked_register_file: directed cases with literal
// expectations, then randomized traffic against an architectural model.
module tb_banked_register_file;
  import regfile_pkg::*;

  localparam int NUM_RD = 3;
  localparam int NUM_WR = 2;
  localparam int DATA_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  banked_register_file_if #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DATA_W(DATA_W)) bus ();

  banked_register_file #(
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .DATA_W    (DATA_W),
    .RESET_MSP (32'h2000_0000),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Architectural model state
  logic [31:0] m_gpr [13];
  logic [31:0] m_sp  [2];
  logic [31:0] m_lr;
  logic [31:0] m_pc;
  logic [15:0] m_pend;
  bit          m_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stored(input logic [3:0] a, input logic s);
    if (a == 4'd15) return m_pc + 32'd4;
    if (a == 4'd14) return m_lr;
    if (a == 4'd13) return m_sp[s];
    return m_gpr[a];
  endfunction

  // Same-cycle forwarding of the last enabled write to the read address.
  function automatic bit bypassHit(input logic [3:0] a, output logic [31:0] d);
    bit hit;
    hit = 1'b0;
    d   = '0;
`ifdef BANKED_REGFILE_BYPASS_EN
    if (a != 4'd15) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w] == a) begin
          hit = 1'b1;
          d   = (a == 4'd13) ? (bus.wr_data[w] & ~32'h3) : bus.wr_data[w];
        end
      end
    end
`endif
    return hit;
  endfunction

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    logic [31:0] d;
    if (bypassHit(a, d)) return d;
    return stored(a, bus.spsel);
  endfunction

  function automatic logic [31:0] modelBusy(input logic [3:0] a);
    logic [31:0] d;
    if (bypassHit(a, d)) return 32'd0;
    return {31'd0, m_pend[a]};
  endfunction

  always @(posedge clk) begin
    logic [31:0] npc;
    if (!rst_n) begin
      for (int i = 0; i < 13; i++) m_gpr[i] = 32'd0;
      m_sp[0] = 32'h2000_0000;
      m_sp[1] = 32'd0;
      m_lr    = 32'hFFFF_FFFF;
      m_pc    = 32'd0;
      m_pend  = 16'd0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      npc = bus.pc_we ? (bus.pc_next & ~32'h1) : m_pc;
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w]) begin
          case (bus.wr_addr[w])
            4'd15:   npc = bus.wr_data[w] & ~32'h1;
            4'd14:   m_lr = bus.wr_data[w];
            4'd13:   m_sp[bus.spsel] = bus.wr_data[w] & ~32'h3;
            default: m_gpr[bus.wr_addr[w]] = bus.wr_data[w];
          endcase
          m_pend[bus.wr_addr[w]] = 1'b0;
        end
      end
      if (bus.sb_set_en && bus.sb_set_addr != 4'd15) m_pend[bus.sb_set_addr] = 1'b1;
      m_pc = npc;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < NUM_RD; k++) begin
        checkOutput($sformatf("model_rd_data%0d@r%0d", k, bus.rd_addr[k]),
                    bus.rd_data[k], modelRead(bus.rd_addr[k]));
        checkOutput($sformatf("model_rd_busy%0d@r%0d", k, bus.rd_addr[k]),
                    {31'd0, bus.rd_busy[k]}, modelBusy(bus.rd_addr[k]));
      end
      checkOutput("model_pc", bus.pc, m_pc);
    end
  end

  task automatic idle();
    bus.rd_addr     = '0;
    bus.wr_en       = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.spsel       = 1'b0;
    bus.pc_we       = 1'b0;
    bus.pc_next     = '0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic [3:0] addr, input logic [31:0] data);
    bus.wr_en[port]   = 1'b1;
    bus.wr_addr[port] = addr;
    bus.wr_data[port] = data;
  endtask

  task automatic randomStimulus();
    rst_n = ($urandom_range(0, 99) != 0);
    for (int k = 0; k < NUM_RD; k++) bus.rd_addr[k] = 4'($urandom_range(0, 15));
    for (int w = 0; w < NUM_WR; w++) begin
      bus.wr_en[w]   = ($urandom_range(0, 2) != 0);
      bus.wr_addr[w] = 4'($urandom_range(0, 15));
      bus.wr_data[w] = $urandom;
    end
    bus.spsel       = 1'($urandom_range(0, 1));
    bus.pc_we       = ($urandom_range(0, 3) == 0);
    bus.pc_next     = $urandom;
    bus.sb_set_en   = ($urandom_range(0, 1) != 0);
    bus.sb_set_addr = 4'($urandom_range(0, 15));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset contents
    bus.rd_addr[0] = 4'd0;
    bus.rd_addr[1] = 4'd13;
    bus.rd_addr[2] = 4'd14;
    #1;
    checkOutput("reset_r0",  bus.rd_data[0], 32'h0000_0000);
    checkOutput("reset_msp", bus.rd_data[1], 32'h2000_0000);
    checkOutput("reset_lr",  bus.rd_data[2], 32'hFFFF_FFFF);
    checkOutput("reset_busy", {29'd0, bus.rd_busy}, 32'd0);
    checkOutput("reset_pc",  bus.pc, 32'h0000_0000);
    checkOutput("model_reset_r15", stored(4'd15, 1'b0), 32'h0000_0004);
    bus.rd_addr[0] = 4'd15;
    #1;
    checkOutput("reset_r15", bus.rd_data[0], 32'h0000_0004);

    // PSP write with alignment, MSP untouched
    step();
    idle();
    bus.spsel = 1'b1;
    applyStimulus(0, 4'd13, 32'h1234_5677);
    step();
    idle();
    bus.spsel      = 1'b1;
    bus.rd_addr[0] = 4'd13;
    #1;
    checkOutput("bank_psp", bus.rd_data[0], 32'h1234_5674);
    bus.spsel = 1'b0;
    #1;
    checkOutput("bank_msp", bus.rd_data[0], 32'h2000_0000);
    checkOutput("model_bank_psp", stored(4'd13, 1'b1), 32'h1234_5674);

    // Same-address collision
    step();
    idle();
    applyStimulus(0, 4'd3, 32'h0000_AAAA);
    applyStimulus(1, 4'd3, 32'h0000_5555);
    step();
    idle();
    bus.rd_addr[0] = 4'd3;
    #1;
    checkOutput("collision_r3", bus.rd_data[0], 32'h0000_5555);

    // Port write to R15 beats pc_we
    step();
    idle();
    bus.pc_we   = 1'b1;
    bus.pc_next = 32'h0000_0100;
    applyStimulus(0, 4'd15, 32'h0000_0201);
    step();
    idle();
    #1;
    checkOutput("pc_priority", bus.pc, 32'h0000_0200);
    bus.rd_addr[0] = 4'd15;
    #1;
    checkOutput("pc_read_r15", bus.rd_data[0], 32'h0000_0204);

    // Scoreboard set, set+clear, clear
    step();
    idle();
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 4'd5;
    bus.rd_addr[0]  = 4'd5;
    #1;
    checkOutput("sb_before_set", {31'd0, bus.rd_busy[0]}, 32'd0);
    step();
    idle();
    bus.rd_addr[0] = 4'd5;
    #1;
    checkOutput("sb_after_set", {31'd0, bus.rd_busy[0]}, 32'd1);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 4'd5;
    applyStimulus(0, 4'd5, 32'h0000_0055);
    step();
    idle();
    bus.rd_addr[0] = 4'd5;
    #1;
    checkOutput("sb_set_wins", {31'd0, bus.rd_busy[0]}, 32'd1);
    applyStimulus(1, 4'd5, 32'h0000_0066);
    #1;
`ifdef BANKED_REGFILE_BYPASS_EN
    checkOutput("sb_clear_same_cycle", {31'd0, bus.rd_busy[0]}, 32'd0);
    checkOutput("bypass_r5", bus.rd_data[0], 32'h0000_0066);
`else
    checkOutput("sb_clear_same_cycle", {31'd0, bus.rd_busy[0]}, 32'd1);
    checkOutput("nobypass_r5", bus.rd_data[0], 32'h0000_0055);
`endif
    step();
    idle();
    bus.rd_addr[0] = 4'd5;
    #1;
    checkOutput("sb_after_clear", {31'd0, bus.rd_busy[0]}, 32'd0);
    checkOutput("r5_after_clear", bus.rd_data[0], 32'h0000_0066);

    // Reset coincident with a write and a scoreboard set
    step();
    idle();
    applyStimulus(0, 4'd1, 32'h0000_DEAD);
    step();
    idle();
    rst_n = 1'b0;
    applyStimulus(0, 4'd1, 32'h0000_BEEF);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 4'd1;
    step();
    rst_n = 1'b1;
    idle();
    bus.rd_addr[0] = 4'd1;
    #1;
    checkOutput("midreset_r1",   bus.rd_data[0], 32'h0000_0000);
    checkOutput("midreset_busy", {31'd0, bus.rd_busy[0]}, 32'd0);
    checkOutput("midreset_pc",   bus.pc, 32'h0000_0000);

    // Randomized traffic checked by the model on every negedge
    for (int n = 0; n < 3000; n++) begin
      step();
      randomStimulus();
    end
    step();
    idle();
    rst_n = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
